// File: rtl/bcd_disp_pkg.sv
// Shared constants for the BCD scan display: nibble width and active-low
// 7-segment patterns ordered {g,f,e,d,c,b,a}.
package bcd_disp_pkg;

  localparam int BCD_W = 4;

  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'h7F;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD nibble to active-low 7-segment decoder; invalid
// nibbles (10..15) show a dash so a corrupted counter is visible.
module bcd_to_seg7
  import bcd_disp_pkg::*;
(
  input  logic [BCD_W-1:0] bcd_i,
  output logic [6:0]       seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_seg_scan.sv
// Time-multiplexed common-anode display scanner with once-per-frame digit
// snapshot. Optional LEADING_ZERO_BLANK_EN blanks leading zero digits.
module bcd_seg_scan
  import bcd_disp_pkg::*;
#(
  parameter int N_DIGITS  = 4,
  parameter int SCAN_DIV  = 1000,
  parameter int BLANK_CYC = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic [BCD_W*N_DIGITS-1:0] digits_in,
  output logic [N_DIGITS-1:0]       an_out,
  output logic [6:0]                seg_out,
  output logic                      frame_tick
);

  localparam int PRE_W = $clog2(SCAN_DIV);
  localparam int IDX_W = $clog2(N_DIGITS);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [PRE_W-1:0] BLANK_L  = PRE_W'(BLANK_CYC);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

  logic [PRE_W-1:0]          pre_cnt_q, pre_cnt_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [BCD_W*N_DIGITS-1:0] shadow_q, shadow_d;
  logic [N_DIGITS-1:0]       an_q, an_d;
  logic [6:0]                seg_q, seg_d;
  logic                      tick_q, tick_d;

  logic [BCD_W-1:0] digit_mux;
  logic [6:0]       seg_dec;
  logic             digit_blank;
  logic             slot_end;

  always_comb begin
    digit_mux = '0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) digit_mux = shadow_q[k*BCD_W +: BCD_W];
    end
  end

  bcd_to_seg7 u_dec (
    .bcd_i (digit_mux),
    .seg_o (seg_dec)
  );

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is blank when it and everything above it is zero; digit 0 always shows.
  logic [N_DIGITS-1:0] lz_blank;
  always_comb begin
    logic lz_above;
    lz_above = 1'b1;
    lz_blank = '0;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      lz_above    = lz_above && (shadow_q[k*BCD_W +: BCD_W] == '0);
      lz_blank[k] = lz_above && (k != 0);
    end
  end

  always_comb begin
    digit_blank = 1'b0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) digit_blank = lz_blank[k];
    end
  end
`else
  assign digit_blank = 1'b0;
`endif

  assign slot_end = (pre_cnt_q == PRE_LAST);

  always_comb begin
    pre_cnt_d = pre_cnt_q;
    idx_d     = idx_q;
    shadow_d  = shadow_q;
    an_d      = '1;
    seg_d     = SEG_OFF;
    tick_d    = 1'b0;
    if (en) begin
      pre_cnt_d = slot_end ? '0 : pre_cnt_q + PRE_W'(1);
      if (slot_end) begin
        idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        if (idx_q == IDX_LAST) begin
          shadow_d = digits_in;
          tick_d   = 1'b1;
        end
      end
      // First BLANK_CYC clocks of a slot keep all anodes off to avoid ghosting.
      if (pre_cnt_q >= BLANK_L) begin
        an_d  = ~(N_DIGITS'(1) << idx_q);
        seg_d = digit_blank ? SEG_OFF : seg_dec;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_cnt_q <= '0;
      idx_q     <= '0;
      shadow_q  <= '0;
      an_q      <= '1;
      seg_q     <= SEG_OFF;
      tick_q    <= 1'b0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      tick_q    <= tick_d;
    end
  end

  assign an_out     = an_q;
  assign seg_out    = seg_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_bcd_seg_scan.sv
// Self-checking bench for bcd_seg_scan (4 digits, 8 clocks/slot, 2 blank
// clocks) against a frame-position reference model.
module tb_bcd_seg_scan;

  localparam int N     = 4;
  localparam int DIV   = 8;
  localparam int BLK   = 2;
  localparam int FRAME = N * DIV;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [15:0] digits_in;
  logic [3:0]  an_out;
  logic [6:0]  seg_out;
  logic        frame_tick;

  int          n_total = 0;
  int          n_pass  = 0;
  int          p;
  int          last_p;
  logic [15:0] shadow;

  always #5 clk = ~clk;

  bcd_seg_scan #(
    .N_DIGITS  (N),
    .SCAN_DIV  (DIV),
    .BLANK_CYC (BLK)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .digits_in  (digits_in),
    .an_out     (an_out),
    .seg_out    (seg_out),
    .frame_tick (frame_tick)
  );

  function automatic logic [6:0] seg_ref(input int v);
    case (v)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  function automatic logic shown(input logic [15:0] sh, input int k);
`ifdef LEADING_ZERO_BLANK_EN
    return (k == 0) || ((int'(sh) >> (4 * k)) != 0);
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [15:0] rand_digits();
    logic [15:0] d;
    d = '0;
    for (int k = 0; k < N; k++) begin
      if ($urandom_range(1) == 1) d = d | (16'($urandom_range(15)) << (4 * k));
    end
    return d;
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One clock: predict outputs from the frame position, then advance the model.
  task automatic step();
    logic [3:0] ean;
    logic [6:0] eseg;
    logic       etick;
    int         slot;
    ean   = 4'hF;
    eseg  = 7'h7F;
    etick = 1'b0;
    if (en) begin
      slot = p / DIV;
      if ((p % DIV) >= BLK) begin
        ean  = ~(4'(1) << slot);
        eseg = shown(shadow, slot) ? seg_ref((int'(shadow) >> (4 * slot)) % 16) : 7'h7F;
      end
      etick = (p == FRAME - 1);
    end
    @(posedge clk);
    #1;
    check("an_model", 16'(an_out), 16'(ean));
    check("seg_model", 16'(seg_out), 16'(eseg));
    check("tick_model", 16'(frame_tick), 16'(etick));
    if (en) begin
      if (p == FRAME - 1) shadow = digits_in;
      last_p = p;
      p = (p + 1) % FRAME;
    end
  endtask

  task automatic run_until(input int target, input int bound);
    int n;
    step();
    n = 1;
    while (last_p != target && n < bound) begin
      step();
      n++;
    end
    check("reach_pos", 16'(last_p), 16'(target));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    en        = 1'b0;
    digits_in = '0;
    p         = 0;
    last_p    = -1;
    shadow    = '0;

    #2 reset = 1'b0;
    #1;
    check("rst_an", 16'(an_out), 16'hF);
    check("rst_seg", 16'(seg_out), 16'h7F);
    check("rst_tick", 16'(frame_tick), 16'h0);
    @(posedge clk);
    #1;
    reset     = 1'b1;
    en        = 1'b1;
    digits_in = 16'h1234;

    run_until(4, 40);
    check("first_frame_an", 16'(an_out), 16'b1110);
    check("first_frame_seg", 16'(seg_out), 16'b1000000);
    run_until(31, 40);
    check("frame_tick", 16'(frame_tick), 16'h1);
    run_until(0, 40);
    check("slot_blank_an", 16'(an_out), 16'hF);
    run_until(4, 40);
    check("d0_an", 16'(an_out), 16'b1110);
    check("d0_seg", 16'(seg_out), 16'b0011001);

    run_until(10, 40);
    digits_in = 16'h9999;
    run_until(20, 40);
    check("hold_d2_an", 16'(an_out), 16'b1011);
    check("hold_d2_seg", 16'(seg_out), 16'b0100100);
    run_until(28, 40);
    check("d3_an", 16'(an_out), 16'b0111);
    check("d3_seg", 16'(seg_out), 16'b1111001);
    run_until(12, 40);
    check("new9_seg", 16'(seg_out), 16'b0010000);

    digits_in = 16'h00A0;
    run_until(31, 40);
    run_until(4, 40);
    check("a0_d0_seg", 16'(seg_out), 16'b1000000);
    run_until(12, 40);
    check("a0_dash_seg", 16'(seg_out), 16'b0111111);
    run_until(20, 40);
    check("a0_d2_an", 16'(an_out), 16'b1011);
`ifdef LEADING_ZERO_BLANK_EN
    check("a0_d2_seg", 16'(seg_out), 16'h7F);
`else
    check("a0_d2_seg", 16'(seg_out), 16'b1000000);
`endif

`ifdef LEADING_ZERO_BLANK_EN
    digits_in = 16'h0050;
    run_until(31, 40);
    run_until(4, 40);
    check("lz50_d0", 16'(seg_out), 16'b1000000);
    run_until(12, 40);
    check("lz50_d1", 16'(seg_out), 16'b0010010);
    run_until(20, 40);
    check("lz50_d2", 16'(seg_out), 16'h7F);
    check("lz50_d2_an", 16'(an_out), 16'b1011);
    run_until(28, 40);
    check("lz50_d3", 16'(seg_out), 16'h7F);
    digits_in = 16'h0000;
    run_until(31, 40);
    run_until(4, 40);
    check("lz0_d0", 16'(seg_out), 16'b1000000);
    run_until(12, 40);
    check("lz0_d1", 16'(seg_out), 16'h7F);
`endif

    run_until(19, 40);
    en = 1'b0;
    repeat (20) step();
    check("en0_an", 16'(an_out), 16'hF);
    check("en0_seg", 16'(seg_out), 16'h7F);
    en = 1'b1;
    step();
    check("resume_pos", 16'(last_p), 16'd20);
    check("resume_an", 16'(an_out), 16'b1011);

    repeat (400) begin
      en = ($urandom_range(7) != 0);
      if ($urandom_range(15) == 0) digits_in = rand_digits();
      step();
    end
    en = 1'b1;

    digits_in = 16'h5678;
    run_until(4, 40);
    check("pre_rst_an", 16'(an_out), 16'b1110);
    #2 reset = 1'b0;
    #1;
    check("midrst_an", 16'(an_out), 16'hF);
    check("midrst_seg", 16'(seg_out), 16'h7F);
    check("midrst_tick", 16'(frame_tick), 16'h0);
    p      = 0;
    last_p = -1;
    shadow = '0;
    @(posedge clk);
    #1;
    check("inrst_an", 16'(an_out), 16'hF);
    reset = 1'b1;
    run_until(4, 40);
    check("post_rst_seg", 16'(seg_out), 16'b1000000);
    check("post_rst_an", 16'(an_out), 16'b1110);
    run_until(31, 40);
    run_until(12, 40);
    check("post_rst_d1", 16'(seg_out), 16'b1111000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
